// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - two-wide dispatch: ROB allocation, source-ready tagging, preg ready scoreboard
// Optional DISPATCH_BYPASS_EN: same-cycle completions also mark sources ready.
// rsEntry (38b): {valid[37], robNum[36:33], src1rdy[32], src2rdy[31], fu[30:28],
//   instruction[27:0] = {RegWrite[27], ALUSrc[26], rd[25:20], rs2[19:14], rs1[13:8], op[7:0]}}
module dispatch_stage #(
    parameter int ROB_DEPTH  = 16,
    parameter int PREG_COUNT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_a,
    input  logic                  in_valid_b,
    input  logic [37:0]           in_entry_a,
    input  logic [37:0]           in_entry_b,
    output logic                  in_ready,
    input  logic [1:0]            retire_cnt,
    input  logic [1:0]            complete_valid,
    input  logic [5:0]            complete_preg0,
    input  logic [5:0]            complete_preg1,
    input  logic                  flush,
    output logic [37:0]           rsLine_a,
    output logic [37:0]           rsLine_b,
    output logic [PREG_COUNT-1:0] phy_reg_rdy,
    output logic [4:0]            rob_count
);

    logic [3:0]            head;
    logic [3:0]            tail;
    logic                  acc_a, acc_b;
    logic [1:0]            n_acc;
    logic [3:0]            slot_b;
    logic [4:0]            count_sum;
    logic [4:0]            count_next;
    logic [PREG_COUNT-1:0] byp_mask;
    logic [PREG_COUNT-1:0] sb_next;
    logic [37:0]           line_a_next, line_b_next;
    logic                  wr_a, wr_b, haz;

    assign in_ready = (rob_count <= 5'(ROB_DEPTH - 2));
    assign acc_a    = in_valid_a && in_ready && !flush;
    assign acc_b    = in_valid_b && in_ready && !flush;
    assign n_acc    = {1'b0, acc_a} + {1'b0, acc_b};
    assign slot_b   = acc_a ? tail + 4'd1 : tail;

    assign wr_a = acc_a && in_entry_a[27] && (in_entry_a[25:20] != 6'd0);
    assign wr_b = acc_b && in_entry_b[27] && (in_entry_b[25:20] != 6'd0);
    assign haz  = wr_a;

`ifdef DISPATCH_BYPASS_EN
    always_comb begin
        byp_mask = '0;
        if (complete_valid[0]) byp_mask[complete_preg0] = 1'b1;
        if (complete_valid[1]) byp_mask[complete_preg1] = 1'b1;
    end
`else
    assign byp_mask = '0;
`endif

    always_comb begin
        line_a_next       = in_entry_a;
        line_a_next[37]   = acc_a;
        line_a_next[36:33] = tail;
        line_a_next[32]   = phy_reg_rdy[in_entry_a[13:8]] | byp_mask[in_entry_a[13:8]];
        line_a_next[31]   = in_entry_a[26] | phy_reg_rdy[in_entry_a[19:14]]
                            | byp_mask[in_entry_a[19:14]];

        // Older slot's destination is not yet produced, so a dependent b must wait.
        line_b_next       = in_entry_b;
        line_b_next[37]   = acc_b;
        line_b_next[36:33] = slot_b;
        line_b_next[32]   = (phy_reg_rdy[in_entry_b[13:8]] | byp_mask[in_entry_b[13:8]])
                            & ~(haz && (in_entry_b[13:8] == in_entry_a[25:20]));
        line_b_next[31]   = in_entry_b[26]
                            | ((phy_reg_rdy[in_entry_b[19:14]] | byp_mask[in_entry_b[19:14]])
                               & ~(haz && (in_entry_b[19:14] == in_entry_a[25:20])));
    end

    // Completions set first so that a same-cycle dispatch clear takes priority.
    always_comb begin
        sb_next = phy_reg_rdy;
        if (complete_valid[0]) sb_next[complete_preg0] = 1'b1;
        if (complete_valid[1]) sb_next[complete_preg1] = 1'b1;
        if (wr_a) sb_next[in_entry_a[25:20]] = 1'b0;
        if (wr_b) sb_next[in_entry_b[25:20]] = 1'b0;
        sb_next[0] = 1'b1;
    end

    always_comb begin
        count_sum = rob_count + {3'b000, n_acc};
        if ({3'b000, retire_cnt} > count_sum) count_next = 5'd0;
        else                                  count_next = count_sum - {3'b000, retire_cnt};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsLine_a    <= '0;
            rsLine_b    <= '0;
            phy_reg_rdy <= '1;
            rob_count   <= 5'd0;
            head        <= 4'd0;
            tail        <= 4'd0;
        end else if (flush) begin
            rsLine_a    <= '0;
            rsLine_b    <= '0;
            phy_reg_rdy <= '1;
            rob_count   <= 5'd0;
            head        <= 4'd0;
            tail        <= 4'd0;
        end else begin
            rsLine_a    <= line_a_next;
            rsLine_b    <= line_b_next;
            phy_reg_rdy <= sb_next;
            rob_count   <= count_next;
            head        <= head + {2'b00, retire_cnt};
            tail        <= tail + {2'b00, n_acc};
        end
    end

endmodule
